// File: rtl/capture_pkg.sv
// Shared types and register layout for the capture sequencer.
// Control and status bit positions live here so firmware headers can mirror them.
package capture_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } cap_state_t;

  localparam int unsigned PixCntW = 10;

  // CTRL register fields
  localparam int unsigned CtrlStartBit = 0;
  localparam int unsigned CtrlAbortBit = 1;
  localparam int unsigned CtrlContBit  = 2;

  // STAT register fields
  localparam int unsigned StatBusyBit    = 0;
  localparam int unsigned StatDoneBit    = 1;
  localparam int unsigned StatTimeoutBit = 2;
  localparam int unsigned StatContBit    = 3;
  localparam int unsigned StatStateLsb   = 4;
  localparam int unsigned StatPixLsb     = 16;

  function automatic logic [31:0] status_word(
    input logic                busy,
    input logic                done,
    input logic                timeout,
    input logic                cont,
    input cap_state_t          state,
    input logic [PixCntW-1:0]  pix
  );
    logic [31:0] w;
    w = '0;
    w[StatBusyBit]              = busy;
    w[StatDoneBit]              = done;
    w[StatTimeoutBit]           = timeout;
    w[StatContBit]              = cont;
    w[StatStateLsb +: 2]        = state;
    w[StatPixLsb +: PixCntW]    = pix;
    return w;
  endfunction

endpackage

// File: rtl/capture_timeout_ctr.sv
// Loadable up-counter bounding the RUN phase; tc flags the last allowed cycle.
module capture_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] TcVal = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc = (cnt_q == TcVal);

endmodule

// File: rtl/capture_sequencer.sv
// CPU-commanded capture controller: arms on CTRL write, starts the compressor on
// the next frame origin, counts pixel writes and flags completion or timeout.
module capture_sequencer
  import capture_pkg::*;
#(
  parameter int unsigned NUM_PIX     = 784,
  parameter int unsigned TIMEOUT_CYC = 2_000_000,
  parameter logic [31:0] CTRL_ADDR   = 32'h0000_C008,
  parameter logic [31:0] STAT_ADDR   = 32'h0000_C009
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        re,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        sel,
  input  logic        frame_sync,
  input  logic        pix_wr,
  output logic        compress_start,
  output logic        capture_busy,
  output logic        done_irq
);

  localparam logic [PixCntW-1:0] PixMax  = PixCntW'(NUM_PIX);
  localparam logic [PixCntW-1:0] PixLast = PixCntW'(NUM_PIX - 1);

  cap_state_t          state_q;
  logic                done_q;
  logic                timeout_q;
  logic                cont_q;
  logic [PixCntW-1:0]  pix_cnt_q;

  logic ctrl_wr, wr_start, wr_abort, wr_cont;
  logic run_start, pix_last, tmo_tc;
  logic unused_wdata;

  assign ctrl_wr  = we && (addr == CTRL_ADDR);
  assign wr_start = ctrl_wr && wdata[CtrlStartBit];
  assign wr_abort = ctrl_wr && wdata[CtrlAbortBit];
  assign wr_cont  = wdata[CtrlContBit];
  assign unused_wdata = ^wdata[31:3];

  assign run_start = (state_q == ARM) && frame_sync && !wr_abort;
  assign pix_last  = pix_wr && (pix_cnt_q == PixLast);

  capture_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout_ctr (
    .clk  (clk),
    .rst  (rst),
    .load (run_start),
    .en   (state_q == RUN),
    .tc   (tmo_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      done_q         <= 1'b0;
      timeout_q      <= 1'b0;
      cont_q         <= 1'b0;
      pix_cnt_q      <= '0;
      compress_start <= 1'b0;
      capture_busy   <= 1'b0;
      done_irq       <= 1'b0;
    end else begin
      compress_start <= 1'b0;
      done_irq       <= 1'b0;
      if (ctrl_wr) begin
        cont_q <= wr_cont;
      end
      if (wr_abort) begin
        // Abort freezes the count and sticky flags so firmware can inspect them.
        state_q      <= IDLE;
        capture_busy <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE, DONE: begin
            // cont_q here is the value latched before this cycle's write.
            if (wr_start || ((state_q == DONE) && cont_q)) begin
              state_q      <= ARM;
              done_q       <= 1'b0;
              timeout_q    <= 1'b0;
              pix_cnt_q    <= '0;
              capture_busy <= 1'b1;
            end
          end
          ARM: begin
            if (frame_sync) begin
              state_q        <= RUN;
              compress_start <= 1'b1;
            end
          end
          RUN: begin
            if (pix_wr && (pix_cnt_q != PixMax)) begin
              pix_cnt_q <= pix_cnt_q + 1'b1;
            end
            if (pix_last) begin
              state_q      <= DONE;
              done_q       <= 1'b1;
              done_irq     <= 1'b1;
              capture_busy <= 1'b0;
            end else if (tmo_tc) begin
              state_q      <= DONE;
              done_q       <= 1'b0;
              timeout_q    <= 1'b1;
              done_irq     <= 1'b1;
              capture_busy <= 1'b0;
            end
          end
          default: begin
            state_q      <= IDLE;
            capture_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sel = re && (addr == STAT_ADDR);

  always_comb begin
    rdata = '0;
    if (sel) begin
      rdata = status_word(capture_busy, done_q, timeout_q, cont_q, state_q, pix_cnt_q);
    end
  end

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: directed scenarios plus randomized traffic, all
// checked every cycle against a cycle-count based behavioural model.
module tb_capture_sequencer;

  localparam int unsigned NPIX = 784;
  localparam int unsigned TMO  = 1000;
  localparam logic [31:0] CTRL_A = 32'h0000_C008;
  localparam logic [31:0] STAT_A = 32'h0000_C009;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        sel;
  logic        frame_sync = 1'b0;
  logic        pix_wr = 1'b0;
  logic        compress_start;
  logic        capture_busy;
  logic        done_irq;

  capture_sequencer #(
    .NUM_PIX     (NPIX),
    .TIMEOUT_CYC (TMO),
    .CTRL_ADDR   (CTRL_A),
    .STAT_ADDR   (STAT_A)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .addr           (addr),
    .re             (re),
    .we             (we),
    .wdata          (wdata),
    .rdata          (rdata),
    .sel            (sel),
    .frame_sync     (frame_sync),
    .pix_wr         (pix_wr),
    .compress_start (compress_start),
    .capture_busy   (capture_busy),
    .done_irq       (done_irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  int n_start = 0, n_irq = 0, start_cyc = 0, irq_cyc = 0;

  // Model: mode 0=idle 1=armed 2=running 3=finished
  int m_mode = 0;
  bit m_done = 0, m_tmo = 0, m_cont = 0, m_cs = 0, m_irq = 0;
  int m_pix = 0;
  int m_run_start = 0;

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin : model
    bit ctrl, st, ab;
    cyc++;
    if (rst) begin
      m_mode = 0; m_done = 0; m_tmo = 0; m_cont = 0; m_pix = 0; m_cs = 0; m_irq = 0;
      chk_en = 1'b1;
    end else begin
      ctrl = we && (addr == CTRL_A);
      st   = ctrl && wdata[0];
      ab   = ctrl && wdata[1];
      m_cs = 0;
      m_irq = 0;
      if (ab) begin
        m_mode = 0;
      end else if (m_mode == 1) begin
        if (frame_sync) begin
          m_mode = 2; m_cs = 1; m_run_start = cyc;
        end
      end else if (m_mode == 2) begin
        if (pix_wr && m_pix < NPIX) m_pix++;
        if (m_pix == NPIX) begin
          m_mode = 3; m_done = 1; m_irq = 1;
        end else if (cyc - m_run_start == TMO) begin
          // TMO cycles of running have elapsed since the start pulse edge
          m_mode = 3; m_done = 0; m_tmo = 1; m_irq = 1;
        end
      end else if (st || (m_mode == 3 && m_cont)) begin
        m_mode = 1; m_done = 0; m_tmo = 0; m_pix = 0;
      end
      if (ctrl) m_cont = wdata[2];
    end
  end

  always @(negedge clk) begin : compare
    logic [31:0] exp_rd;
    bit exp_sel, exp_busy;
    if (compress_start === 1'b1) begin n_start++; start_cyc = cyc; end
    if (done_irq === 1'b1) begin n_irq++; irq_cyc = cyc; end
    if (chk_en) begin
      exp_busy = (m_mode == 1) || (m_mode == 2);
      exp_sel  = re && (addr == STAT_A);
      exp_rd   = exp_sel ? (32'(exp_busy) + 32'(m_done) * 2 + 32'(m_tmo) * 4 + 32'(m_cont) * 8
                            + 32'(m_mode) * 16 + 32'(m_pix) * 65536) : 32'd0;
      check("cycle", {compress_start, capture_busy, done_irq, sel, rdata},
            {m_cs, exp_busy, m_irq, exp_sel, exp_rd});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ctrl_write(input logic [31:0] d);
    we = 1'b1; addr = CTRL_A; wdata = d;
    tick(1);
    we = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic frame();
    frame_sync = 1'b1;
    tick(1);
    frame_sync = 1'b0;
  endtask

  task automatic pixels(input int n, input int gap);
    repeat (n) begin
      pix_wr = 1'b1;
      tick(1);
      pix_wr = 1'b0;
      tick(gap);
    end
  endtask

  task automatic read_stat(output logic [31:0] v);
    re = 1'b1; addr = STAT_A;
    @(negedge clk);
    v = rdata;
    @(posedge clk);
    #1;
    re = 1'b0; addr = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic reset_check(input string name);
    logic [34:0] v;
    rst = 1'b1;
    tick(1);
    rst = 1'b0; re = 1'b1; addr = STAT_A;
    @(negedge clk);
    v = {compress_start, capture_busy, done_irq, rdata};
    check(name, 36'(v), 36'd0);
    @(posedge clk);
    #1;
    re = 1'b0; addr = '0;
  endtask

  int fs_cyc, s0, i0, dens;
  logic [31:0] v;

  initial begin
    do_reset();
    tick(1);
    read_stat(v);
    check("reset_stat", 36'(v), 36'd0);

    // Nominal capture
    s0 = n_start; i0 = n_irq;
    ctrl_write(32'h1);
    tick(10);
    fs_cyc = cyc;
    frame();
    pixels(NPIX, 0);
    tick(2);
    check("nom_starts", 36'(n_start - s0), 36'd1);
    check("nom_start_lat", 36'(start_cyc - fs_cyc), 36'd1);
    check("nom_irqs", 36'(n_irq - i0), 36'd1);
    check("nom_busy", 36'(capture_busy), 36'd0);
    read_stat(v);
    check("nom_stat", 36'(v), 36'h0_0310_0032);

    // Timeout after 5 pixels
    ctrl_write(32'h1);
    tick(3);
    frame();
    pixels(5, 3);
    tick(TMO + 10);
    check("tmo_latency", 36'(irq_cyc - start_cyc), 36'd1000);
    read_stat(v);
    check("tmo_stat", 36'(v), 36'h0_0005_0034);

    // Abort mid-run
    ctrl_write(32'h1);
    frame();
    pixels(100, 0);
    i0 = n_irq;
    ctrl_write(32'h2);
    check("abort_busy", 36'(capture_busy), 36'd0);
    pixels(20, 1);
    read_stat(v);
    check("abort_stat", 36'(v), 36'h0_0064_0000);
    check("abort_no_irq", 36'(n_irq - i0), 36'd0);

    // Ignored events
    do_reset();
    s0 = n_start;
    frame();
    pixels(5, 1);
    read_stat(v);
    check("idle_ignore", 36'(v), 36'd0);
    ctrl_write(32'h1);
    frame();
    pixels(10, 0);
    ctrl_write(32'h1);
    pixels(10, 0);
    read_stat(v);
    check("restart_ignored", 36'(v), 36'h0_0014_0021);
    ctrl_write(32'h3);
    ctrl_write(32'h3);
    read_stat(v);
    check("start_abort_idle", 36'(v), 36'h0_0014_0000);
    check("ignore_starts", 36'(n_start - s0), 36'd1);

    // Continuous mode
    do_reset();
    s0 = n_start; i0 = n_irq;
    ctrl_write(32'h5);
    frame();
    pixels(NPIX, 0);
    tick(3);
    frame();
    pixels(NPIX, 0);
    tick(3);
    check("cont_starts", 36'(n_start - s0), 36'd2);
    check("cont_irqs", 36'(n_irq - i0), 36'd2);
    read_stat(v);
    check("cont_rearm_stat", 36'(v), 36'h0_0000_0019);

    // Reset mid-ARM and mid-RUN
    ctrl_write(32'h1);
    reset_check("rst_mid_arm");
    s0 = n_start;
    ctrl_write(32'h1);
    frame();
    pixels(50, 0);
    reset_check("rst_mid_run");
    tick(5);
    check("rst_no_repulse", 36'(n_start - s0), 36'd1);

    // Randomized traffic
    dens = 97;
    for (int i = 0; i < 16000; i++) begin
      int k;
      if (i % 2000 == 0) dens = ($urandom_range(0, 1) == 1) ? 97 : 30;
      rst = ($urandom_range(0, 2999) == 0);
      we  = ($urandom_range(0, 199) == 0);
      re  = ($urandom_range(0, 3) == 0);
      k   = $urandom_range(0, 9);
      if (k < 6)      addr = we ? CTRL_A : STAT_A;
      else if (k < 8) addr = we ? STAT_A : CTRL_A;
      else            addr = $urandom;
      wdata = $urandom;
      wdata[1] = ($urandom_range(0, 3) == 0);
      frame_sync = ($urandom_range(0, 49) == 0);
      pix_wr = ($urandom_range(0, 99) < dens);
      tick(1);
    end
    rst = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
    frame_sync = 1'b0; pix_wr = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
